// File: rtl/video_source_sequencer_pkg.sv
// Shared encodings for the video source sequencer: mixer source codes,
// sequencer states and counter widths.
package video_pkg;

   typedef enum logic [1:0] {
      SRC_PI       = 2'd0,
      SRC_TESTCARD = 2'd1,
      SRC_OVERLAY  = 2'd2,
      SRC_BLACK    = 2'd3
   } src_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_MUTE,
      ST_COMMIT
   } state_t;

   localparam int TIMEOUT_W = 19;
   localparam int FIELD_W   = 3;

endpackage

// File: rtl/video_source_sequencer_if.sv
// Source-change request channel between a controller and the sequencer.
interface video_source_sequencer_if;

   // reqValid/reqReady: a request transfers on a cycle where both are high.
   // Requests offered while reqReady is low are dropped, never queued.
   logic       reqValid;
   logic [1:0] reqSource;
   logic       reqReady;

   modport master (output reqValid, output reqSource, input reqReady);
   modport slave  (input reqValid, input reqSource, output reqReady);

endinterface

// File: rtl/video_source_sequencer_fieldstart_detect.sv
// Enable-gated sampler for an active-low sync; pulses on a 1->0 transition
// seen across two consecutive enable cycles.
module fieldstart_detect (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_n,
   output logic start
);

   logic sample_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q <= 1'b0;
      end else if (en) begin
         sample_q <= sync_n;
      end
   end

   assign start = en & sample_q & ~sync_n;

endmodule

// File: rtl/video_source_sequencer.sv
// Switches the mixer source only at field boundaries, muting whole fields
// around the change and forcing the switch if vSync disappears.
module video_source_sequencer
   import video_pkg::*;
#(
   parameter int         MUTE_FIELDS    = 2,
   parameter int         TIMEOUT_PIXELS = 400000,
   parameter logic [1:0] DEFAULT_SOURCE = SRC_PI
) (
   input  logic                    pixelClockX6,
   input  logic                    reset,
   input  logic                    pixelClockX1_en,
   input  logic                    vSync,
   video_source_sequencer_if.slave req,
   output logic [1:0]              srcSelect,
   output logic                    muteActive,
   output logic                    switchDone,
   output logic                    timeoutFlag,
   output state_t                  fsm_state
);

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_PIXELS - 1);
   localparam logic [FIELD_W-1:0]   MUTE_LOAD    = FIELD_W'(MUTE_FIELDS);

   state_t               state_q, state_d;
   logic [1:0]           src_q, src_d, pend_q, pend_d;
   logic                 mute_q, mute_d, done_q, done_d, tflag_q, tflag_d;
   logic [FIELD_W-1:0]   fcnt_q, fcnt_d;
   logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
   logic                 field_start, accept, timeout_hit, commit;

   fieldstart_detect u_field (
      .clk    (pixelClockX6),
      .rst    (reset),
      .en     (pixelClockX1_en),
      .sync_n (vSync),
      .start  (field_start)
   );

   assign req.reqReady = (state_q == ST_IDLE);
   assign accept       = req.reqValid && req.reqReady;
   // A field start on the last allowed pixel beats the timeout.
   assign timeout_hit  = pixelClockX1_en && !field_start && (tcnt_q == TIMEOUT_LAST);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      pend_d  = pend_q;
      mute_d  = mute_q;
      done_d  = 1'b0;
      tflag_d = tflag_q;
      fcnt_d  = fcnt_q;
      tcnt_d  = tcnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req.reqSource == src_q) begin
                  done_d = 1'b1;
               end else begin
                  pend_d  = req.reqSource;
                  tflag_d = 1'b0;
                  tcnt_d  = '0;
                  state_d = ST_ALIGN;
               end
            end
         end
         ST_ALIGN, ST_MUTE: begin
            if (field_start) begin
               tcnt_d = '0;
               if (state_q == ST_ALIGN) begin
                  if (MUTE_FIELDS == 0) begin
                     commit = 1'b1;
                  end else begin
                     mute_d  = 1'b1;
                     fcnt_d  = MUTE_LOAD;
                     state_d = ST_MUTE;
                  end
               end else if (fcnt_q <= 1) begin
                  commit = 1'b1;
               end else begin
                  fcnt_d = fcnt_q - 1'b1;
               end
            end else if (timeout_hit) begin
               tflag_d = 1'b1;
               commit  = 1'b1;
            end else if (pixelClockX1_en) begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // Commit results are registered on entry so they are visible during
      // the single COMMIT cycle, i.e. the cycle after the deciding event.
      if (commit) begin
         state_d = ST_COMMIT;
         src_d   = pend_q;
         mute_d  = 1'b0;
         done_d  = 1'b1;
         fcnt_d  = '0;
      end
   end

   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= DEFAULT_SOURCE;
         pend_q  <= DEFAULT_SOURCE;
         mute_q  <= 1'b0;
         done_q  <= 1'b0;
         tflag_q <= 1'b0;
         fcnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         pend_q  <= pend_d;
         mute_q  <= mute_d;
         done_q  <= done_d;
         tflag_q <= tflag_d;
         fcnt_q  <= fcnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign srcSelect   = src_q;
   assign muteActive  = mute_q;
   assign switchDone  = done_q;
   assign timeoutFlag = tflag_q;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_video_source_sequencer.sv
// Bench for video_source_sequencer: three parameterisations share clock,
// enable, reset and vSync; each has its own request channel.
module tb_video_source_sequencer;
   import video_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic vs  = 1'b1;
   int   div = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
   logic mute_seen_a = 1'b0, mute_seen_b = 1'b0, mute_seen_c = 1'b0;
   logic [4:0] exp_q[$];

   logic [1:0] sel_a, sel_b, sel_c;
   logic       mute_a, mute_b, mute_c, done_a, done_b, done_c, tflag_a, tflag_b, tflag_c;
   state_t     st_a, st_b, st_c;

   video_source_sequencer_if if_a ();
   video_source_sequencer_if if_b ();
   video_source_sequencer_if if_c ();

   always #5 clk = ~clk;

   video_source_sequencer #(.MUTE_FIELDS(2), .TIMEOUT_PIXELS(400000), .DEFAULT_SOURCE(SRC_PI)) dut_a (
      .pixelClockX6(clk), .reset(rst), .pixelClockX1_en(en), .vSync(vs), .req(if_a),
      .srcSelect(sel_a), .muteActive(mute_a), .switchDone(done_a), .timeoutFlag(tflag_a), .fsm_state(st_a));

   video_source_sequencer #(.MUTE_FIELDS(0), .TIMEOUT_PIXELS(400000), .DEFAULT_SOURCE(SRC_PI)) dut_b (
      .pixelClockX6(clk), .reset(rst), .pixelClockX1_en(en), .vSync(vs), .req(if_b),
      .srcSelect(sel_b), .muteActive(mute_b), .switchDone(done_b), .timeoutFlag(tflag_b), .fsm_state(st_b));

   video_source_sequencer #(.MUTE_FIELDS(2), .TIMEOUT_PIXELS(500), .DEFAULT_SOURCE(SRC_TESTCARD)) dut_c (
      .pixelClockX6(clk), .reset(rst), .pixelClockX1_en(en), .vSync(vs), .req(if_c),
      .srcSelect(sel_c), .muteActive(mute_c), .switchDone(done_c), .timeoutFlag(tflag_c), .fsm_state(st_c));

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   // Scoreboard: pop one expected {dut, src, tflag} word per switchDone pulse.
   task automatic sb_pop(input logic [1:0] id, input logic [1:0] sel, input logic tf);
      logic [4:0] got, exp;
      got = {id, sel, tf};
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL sb_unexpected_done dut%0d: got src=%0d tflag=%0b, expected no pulse", id, sel, tf);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp)
            $display("FAIL sb_done: got dut%0d src=%0d tflag=%0b, expected dut%0d src=%0d tflag=%0b",
                     got[4:3], got[2:1], got[0], exp[4:3], exp[2:1], exp[0]);
         else n_pass++;
      end
   endtask

   // One clock: observe outputs just after the edge, then drive the enable
   // for the coming cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      mute_seen_a |= (mute_a === 1'b1);
      mute_seen_b |= (mute_b === 1'b1);
      mute_seen_c |= (mute_c === 1'b1);
      if (done_a === 1'b1) begin done_cnt_a++; sb_pop(2'd0, sel_a, tflag_a); end
      if (done_b === 1'b1) begin done_cnt_b++; sb_pop(2'd1, sel_b, tflag_b); end
      if (done_c === 1'b1) begin done_cnt_c++; sb_pop(2'd2, sel_c, tflag_c); end
      div = (div == 5) ? 0 : div + 1;
      en  = (div == 0);
   endtask

   task automatic next_en();
      while (!en) tick();
   endtask

   // One pixel-enable cycle with the given vSync level.
   task automatic pix(input logic v);
      next_en();
      vs = v;
      tick();
   endtask

   task automatic fields(input int n, input int gap);
      repeat (n) begin
         repeat (gap) pix(1'b1);
         pix(1'b0);
      end
   endtask

   task automatic request(input int id, input logic [1:0] src);
      logic rdy;
      for (int i = 0; i < 8; i++) begin
         rdy = (id == 0) ? if_a.reqReady : (id == 1) ? if_b.reqReady : if_c.reqReady;
         if (rdy === 1'b1) break;
         tick();
      end
      n_checks++;
      if (rdy !== 1'b1) $display("FAIL req_ready dut%0d: got %b expected 1", id, rdy); else n_pass++;
      case (id)
         0: begin if_a.reqValid = 1'b1; if_a.reqSource = src; end
         1: begin if_b.reqValid = 1'b1; if_b.reqSource = src; end
         default: begin if_c.reqValid = 1'b1; if_c.reqSource = src; end
      endcase
      tick();
      if_a.reqValid = 1'b0;
      if_b.reqValid = 1'b0;
      if_c.reqValid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vs  = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      n_checks++; if (sel_a !== 2'd0) $display("FAIL rst_sel_a got=%0d exp=0", sel_a); else n_pass++;
      n_checks++; if (sel_c !== 2'd1) $display("FAIL rst_sel_c got=%0d exp=1", sel_c); else n_pass++;
      n_checks++; if ({mute_a, done_a, tflag_a} !== 3'b000) $display("FAIL rst_flags_a got=%b exp=000", {mute_a, done_a, tflag_a}); else n_pass++;
      n_checks++; if (st_a !== ST_IDLE) $display("FAIL rst_state_a got=%0d exp=%0d", st_a, ST_IDLE); else n_pass++;
      tick();
      n_checks++; if (if_a.reqReady !== 1'b1) $display("FAIL rst_ready_a got=%b exp=1", if_a.reqReady); else n_pass++;
      mute_seen_a = 1'b0; mute_seen_b = 1'b0; mute_seen_c = 1'b0;
      done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
   endtask

   task automatic test_same_source();
      exp_q.push_back({2'd0, 2'd0, 1'b0});
      request(0, 2'd0);
      n_checks++; if (done_a !== 1'b1) $display("FAIL same_done got=%b exp=1", done_a); else n_pass++;
      n_checks++; if (if_a.reqReady !== 1'b1) $display("FAIL same_ready got=%b exp=1", if_a.reqReady); else n_pass++;
      tick();
      n_checks++; if (done_a !== 1'b0) $display("FAIL same_done_clear got=%b exp=0", done_a); else n_pass++;
      n_checks++; if (mute_seen_a !== 1'b0) $display("FAIL same_mute got=%b exp=0", mute_seen_a); else n_pass++;
   endtask

   task automatic test_switch();
      exp_q.push_back({2'd0, 2'd1, 1'b0});
      request(0, 2'd1);
      repeat (999) pix(1'b1);
      n_checks++; if (st_a !== ST_ALIGN || mute_a !== 1'b0) $display("FAIL sw_align got st=%0d mute=%b exp st=%0d mute=0", st_a, mute_a, ST_ALIGN); else n_pass++;
      pix(1'b0);
      n_checks++; if (mute_a !== 1'b1 || sel_a !== 2'd0) $display("FAIL sw_fs1 got mute=%b sel=%0d exp mute=1 sel=0", mute_a, sel_a); else n_pass++;
      repeat (999) pix(1'b1);
      pix(1'b0);
      n_checks++; if (mute_a !== 1'b1 || sel_a !== 2'd0) $display("FAIL sw_fs2 got mute=%b sel=%0d exp mute=1 sel=0", mute_a, sel_a); else n_pass++;
      repeat (999) pix(1'b1);
      pix(1'b0);
      n_checks++; if (sel_a !== 2'd1 || done_a !== 1'b1 || mute_a !== 1'b0) $display("FAIL sw_fs3 got sel=%0d done=%b mute=%b exp sel=1 done=1 mute=0", sel_a, done_a, mute_a); else n_pass++;
      tick();
      n_checks++; if (st_a !== ST_IDLE || done_a !== 1'b0) $display("FAIL sw_idle got st=%0d done=%b exp st=%0d done=0", st_a, done_a, ST_IDLE); else n_pass++;
   endtask

   task automatic test_no_mute();
      mute_seen_b = 1'b0;
      repeat (5) pix(1'b1);
      next_en();
      vs = 1'b0;
      n_checks++; if (if_b.reqReady !== 1'b1) $display("FAIL nm_ready got=%b exp=1", if_b.reqReady); else n_pass++;
      if_b.reqValid = 1'b1;
      if_b.reqSource = 2'd3;
      exp_q.push_back({2'd1, 2'd3, 1'b0});
      tick();
      if_b.reqValid = 1'b0;
      repeat (10) pix(1'b1);
      n_checks++; if (st_b !== ST_ALIGN || sel_b !== 2'd0) $display("FAIL nm_wait got st=%0d sel=%0d exp st=%0d sel=0", st_b, sel_b, ST_ALIGN); else n_pass++;
      pix(1'b0);
      n_checks++; if (sel_b !== 2'd3 || done_b !== 1'b1) $display("FAIL nm_commit got sel=%0d done=%b exp sel=3 done=1", sel_b, done_b); else n_pass++;
      n_checks++; if (mute_seen_b !== 1'b0) $display("FAIL nm_mute got=%b exp=0", mute_seen_b); else n_pass++;
   endtask

   task automatic test_timeout();
      exp_q.push_back({2'd2, 2'd2, 1'b1});
      request(2, 2'd2);
      repeat (499) pix(1'b1);
      n_checks++; if (st_c !== ST_ALIGN || sel_c !== 2'd1) $display("FAIL to_early got st=%0d sel=%0d exp st=%0d sel=1", st_c, sel_c, ST_ALIGN); else n_pass++;
      pix(1'b1);
      n_checks++; if (sel_c !== 2'd2 || tflag_c !== 1'b1 || done_c !== 1'b1) $display("FAIL to_forced got sel=%0d tflag=%b done=%b exp sel=2 tflag=1 done=1", sel_c, tflag_c, done_c); else n_pass++;
      exp_q.push_back({2'd2, 2'd0, 1'b0});
      request(2, 2'd0);
      n_checks++; if (tflag_c !== 1'b0) $display("FAIL to_clear got=%b exp=0", tflag_c); else n_pass++;
      fields(3, 10);
      n_checks++; if (sel_c !== 2'd0) $display("FAIL to_next_sel got=%0d exp=0", sel_c); else n_pass++;
      exp_q.push_back({2'd2, 2'd3, 1'b0});
      request(2, 2'd3);
      repeat (499) pix(1'b1);
      pix(1'b0);
      n_checks++; if (st_c !== ST_MUTE || mute_c !== 1'b1 || tflag_c !== 1'b0) $display("FAIL to_tie got st=%0d mute=%b tflag=%b exp st=%0d mute=1 tflag=0", st_c, mute_c, tflag_c, ST_MUTE); else n_pass++;
      fields(2, 10);
      n_checks++; if (sel_c !== 2'd3 || tflag_c !== 1'b0) $display("FAIL to_tie_commit got sel=%0d tflag=%b exp sel=3 tflag=0", sel_c, tflag_c); else n_pass++;
   endtask

   task automatic test_back_to_back();
      done_cnt_a = 0;
      exp_q.push_back({2'd0, 2'd2, 1'b0});
      request(0, 2'd2);
      fields(1, 10);
      n_checks++; if (mute_a !== 1'b1 || if_a.reqReady !== 1'b0) $display("FAIL b2b_mute got mute=%b ready=%b exp mute=1 ready=0", mute_a, if_a.reqReady); else n_pass++;
      if_a.reqValid = 1'b1;
      if_a.reqSource = 2'd3;
      repeat (5) pix(1'b1);
      n_checks++; if (st_a !== ST_MUTE || if_a.reqReady !== 1'b0) $display("FAIL b2b_ignored got st=%0d ready=%b exp st=%0d ready=0", st_a, if_a.reqReady, ST_MUTE); else n_pass++;
      if_a.reqValid = 1'b0;
      fields(2, 10);
      repeat (20) tick();
      n_checks++; if (sel_a !== 2'd2) $display("FAIL b2b_sel got=%0d exp=2", sel_a); else n_pass++;
      n_checks++; if (done_cnt_a != 1) $display("FAIL b2b_done_count got=%0d exp=1", done_cnt_a); else n_pass++;
   endtask

   task automatic test_reset_mid();
      done_cnt_a = 0;
      request(0, 2'd1);
      fields(2, 10);
      n_checks++; if (st_a !== ST_MUTE || mute_a !== 1'b1) $display("FAIL rm_in_mute got st=%0d mute=%b exp st=%0d mute=1", st_a, mute_a, ST_MUTE); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (sel_a !== 2'd0 || mute_a !== 1'b0 || done_a !== 1'b0 || st_a !== ST_IDLE) $display("FAIL rm_state got sel=%0d mute=%b done=%b st=%0d exp sel=0 mute=0 done=0 st=%0d", sel_a, mute_a, done_a, st_a, ST_IDLE); else n_pass++;
      fields(3, 10);
      n_checks++; if (done_cnt_a != 0 || sel_a !== 2'd0) $display("FAIL rm_no_done got count=%0d sel=%0d exp count=0 sel=0", done_cnt_a, sel_a); else n_pass++;
   endtask

   initial begin
      if_a.reqValid = 1'b0; if_a.reqSource = 2'd0;
      if_b.reqValid = 1'b0; if_b.reqSource = 2'd0;
      if_c.reqValid = 1'b0; if_c.reqSource = 2'd0;
      test_reset();
      test_same_source();
      test_switch();
      test_no_mute();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
